// File: rtl/bit32_1to3_distributor_pkg.sv
// Shared select encoding and default sizing for the 3-to-1 selector / 1-to-3 distributor pair.
package dist_pkg;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_CH0  = 2'd0;
    localparam sel_t SEL_CH1  = 2'd1;
    localparam sel_t SEL_CH2  = 2'd2;
    localparam sel_t SEL_NONE = 2'd3;

    localparam int NUM_CH    = 3;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 2;
    localparam int DEF_CNT_W = 8;

    // One-hot channel enable for a select code; SEL_NONE maps to no channel.
    function automatic logic [NUM_CH-1:0] sel_onehot(input sel_t sel);
        logic [NUM_CH-1:0] oh;
        oh = '0;
        case (sel)
            SEL_CH0: oh = 3'b001;
            SEL_CH1: oh = 3'b010;
            SEL_CH2: oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/bit32_1to3_distributor_if.sv
// Input stream plus three output streams of the distributor, grouped as one bundle.
interface bit32_1to3_distributor_if #(
    parameter int WIDTH = dist_pkg::DEF_WIDTH
);
    logic [WIDTH-1:0]  in_data;
    dist_pkg::sel_t    in_sel;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  out_data0;
    logic [WIDTH-1:0]  out_data1;
    logic [WIDTH-1:0]  out_data2;
    logic [2:0]        out_valid;
    logic [2:0]        out_ready;

    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data0, out_data1, out_data2, out_valid
    );

    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data0, out_data1, out_data2, out_valid
    );

endinterface

// File: rtl/bit32_1to3_distributor_fifo.sv
// Synchronous FIFO with extra-MSB pointers; head is registered storage, no bypass path.
module dist_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr[AW-1:0]] <= wr_data;
                wr_ptr              <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/bit32_1to3_distributor.sv
// Steers a tagged input stream into three buffered output channels; unused tag is dropped and counted.
module bit32_1to3_distributor
    import dist_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    bit32_1to3_distributor_if.slave bus,
    output logic [CNT_W-1:0]       drop_cnt,
    output logic                   sel_err
);
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;
    logic [WIDTH-1:0]  head [NUM_CH];
    logic              rdy;
    logic              xfer;
    logic              drop;

    // Ready looks only at the registered full flag of the targeted channel.
    always_comb begin
        rdy = 1'b1;
        case (bus.in_sel)
            SEL_CH0: rdy = !full[0];
            SEL_CH1: rdy = !full[1];
            SEL_CH2: rdy = !full[2];
            default: rdy = 1'b1;
        endcase
    end

    assign bus.in_ready = rdy;
    assign xfer         = bus.in_valid && rdy;
    assign push         = xfer ? sel_onehot(bus.in_sel) : '0;
    assign drop         = xfer && (bus.in_sel == SEL_NONE);
    assign pop          = bus.out_ready & ~empty;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        dist_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .push    (push[g]),
            .pop     (pop[g]),
            .wr_data (bus.in_data),
            .full    (full[g]),
            .empty   (empty[g]),
            .head    (head[g])
        );
    end

    assign bus.out_valid = ~empty;
    assign bus.out_data0 = head[0];
    assign bus.out_data1 = head[1];
    assign bus.out_data2 = head[2];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_cnt <= '0;
            sel_err  <= 1'b0;
        end else if (drop) begin
            sel_err <= 1'b1;
            if (drop_cnt != {CNT_W{1'b1}}) begin
                drop_cnt <= drop_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule
